// File: rtl/toggle_decoder_if.sv
// Event handshake bundle between the toggle decoder (master) and its consumer (slave).
// One event moves on every rising clk edge where evt_valid and evt_ready are both high.
interface toggle_decoder_if #(
  parameter int PEND_W = 3
);
  logic              evt_valid;
  logic              evt_ready;
  logic [PEND_W-1:0] pend;

  modport master (
    output evt_valid,
    output pend,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  pend,
    output evt_ready
  );
endinterface

// File: rtl/toggle_decoder.sv
// Consumer end of a T flip-flop event link: synchronise, glitch-filter, rebuild the far-end
// level, and queue each accepted toggle as an event with a wrap-around toggle counter.
module toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 3,
  parameter int CNT_W       = 8,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t_in,
  input  logic              en,
  input  logic              clr_ovf,
  toggle_decoder_if.master  evt,
  output logic [CNT_W-1:0]  count,
  output logic              lvl,
  output logic              ovf,
  output logic              filt_state
);

  localparam int QW = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic {
    STABLE = 1'b0,
    QUAL   = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [QW-1:0]          qcnt_q;
  logic                   lvl_q;
  logic [PEND_W-1:0]      pend_q;
  logic [CNT_W-1:0]       count_q;
  logic                   ovf_q;
  logic                   s;
  logic                   accept;
  logic                   xfer;
  logic                   take;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
    end
  end

  // A toggle is accepted on the FILTER-th consecutive cycle of disagreement with lvl.
  always_comb begin
    accept = 1'b0;
    if (s != lvl_q) begin
      if (state_q == STABLE) begin
        accept = (FILTER == 1);
      end else begin
        accept = (qcnt_q == QW'(FILTER - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      lvl_q   <= 1'b0;
      qcnt_q  <= '0;
    end else begin
      case (state_q)
        STABLE: begin
          if (s != lvl_q) begin
            if (accept) begin
              lvl_q <= s;
            end else begin
              state_q <= QUAL;
              qcnt_q  <= QW'(1);
            end
          end
        end
        QUAL: begin
          if (s == lvl_q) begin
            state_q <= STABLE;
            qcnt_q  <= '0;
          end else if (accept) begin
            lvl_q   <= s;
            state_q <= STABLE;
            qcnt_q  <= '0;
          end else begin
            qcnt_q <= qcnt_q + QW'(1);
          end
        end
        default: begin
          state_q <= STABLE;
          qcnt_q  <= '0;
        end
      endcase
    end
  end

  // Accepts while disabled still move lvl, so re-enabling never replays a stale edge.
  assign xfer = evt.evt_valid & evt.evt_ready;
  assign take = accept & en;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (take) begin
        count_q <= count_q + CNT_W'(1);
        if (!xfer) begin
          if (&pend_q) begin
            ovf_q <= 1'b1;
          end else begin
            pend_q <= pend_q + PEND_W'(1);
          end
        end
      end else if (xfer) begin
        pend_q <= pend_q - PEND_W'(1);
      end
      if (clr_ovf && !(take && !xfer && (&pend_q))) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = (pend_q != '0);
  assign evt.pend      = pend_q;
  assign count         = count_q;
  assign lvl           = lvl_q;
  assign ovf           = ovf_q;
  assign filt_state    = state_q;

endmodule
